// File: rtl/cp0_exc_seq.sv
// Coprocessor-0 register file and exception/interrupt sequencer.
// Sits at the M stage. Decides whether the M instruction traps, is
// interrupted or executes ERET. Drives the pipeline flush and the one-cycle
// PC redirect that follows. Owns SR, Cause, EPC and PRId.
module cp0_exc_seq #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h2017_1226
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exccode_m,
    input  logic [5:0]  hwint,
    input  logic        eret_m,
    input  logic        mtc0_m,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        exl
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // RUN evaluates the M instruction. ENTRY and RETURN each last one cycle
    // and carry the redirect to the handler or back to EPC.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  sr_im_r;
    logic        sr_exl_r;
    logic        sr_ie_r;
    logic        cause_bd_r;
    logic [4:0]  cause_code_r;
    logic [5:0]  cause_ip_r;
    logic [31:0] epc_r;
    logic        redirect_r;
    logic [31:0] redirect_pc_r;

    logic        in_run_s;
    logic        int_p_s;
    logic        exc_p_s;
    logic        take_s;
    logic        eret_go_s;
    logic        mtc0_go_s;
    logic [31:0] epc_next_s;
    logic [31:0] rdata_s;

    // SR image: IM in [15:10], EXL in [1], IE in [0]. All other bits are zero.
    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl_bit,
                                            input logic       ie);
        pack_sr = {16'h0000, im, 8'h00, exl_bit, ie};
    endfunction

    // Cause image: BD in [31], IP in [15:10], ExcCode in [6:2].
    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] code);
        pack_cause = {bd, 15'h0000, ip, 3'b000, code, 2'b00};
    endfunction

    // A delay-slot instruction restarts at its branch. The subtraction wraps
    // modulo 2^32.
    function automatic logic [31:0] trap_epc(input logic [31:0] pc,
                                             input logic        bd);
        trap_epc = bd ? (pc - 32'd4) : pc;
    endfunction

    assign in_run_s  = (state_r == ST_RUN);
    assign int_p_s   = (|(hwint & sr_im_r)) & sr_ie_r & ~sr_exl_r;
    assign exc_p_s   = valid_m & (exccode_m != 5'd0);
    assign take_s    = in_run_s & valid_m & (int_p_s | exc_p_s);
    assign eret_go_s = in_run_s & valid_m & eret_m & ~take_s;
    assign mtc0_go_s = in_run_s & valid_m & mtc0_m & ~take_s;

    // Flush is needed in the deciding cycle and throughout the redirect cycle.
    assign flush       = take_s | eret_go_s | ~in_run_s;
    assign redirect    = redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign exl         = sr_exl_r;
    assign cp0_rdata   = rdata_s;

    // Next EPC: a trap captures the restart PC, and MTC0 writes a word-aligned value.
    always_comb begin
        epc_next_s = epc_r;
        if (take_s) begin
            epc_next_s = trap_epc(pc_m, bd_m);
        end else if (mtc0_go_s && (cp0_addr == ADDR_EPC)) begin
            epc_next_s = {cp0_wdata[31:2], 2'b00};
        end else begin
            epc_next_s = epc_r;
        end
    end

    // MFC0 read mux. It reads the current registers, so a same-cycle MTC0 is not forwarded.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (cp0_addr)
            ADDR_SR:    rdata_s = pack_sr(sr_im_r, sr_exl_r, sr_ie_r);
            ADDR_CAUSE: rdata_s = pack_cause(cause_bd_r, cause_ip_r, cause_code_r);
            ADDR_EPC:   rdata_s = epc_r;
            ADDR_PRID:  rdata_s = PRID_VAL;
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Sequencer FSM with the registered redirect outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (take_s) begin
                        state_r       <= ST_ENTRY;
                        redirect_r    <= 1'b1;
                        redirect_pc_r <= HANDLER_PC;
                    end else if (eret_go_s) begin
                        state_r       <= ST_RETURN;
                        redirect_r    <= 1'b1;
                        redirect_pc_r <= epc_next_s;
                    end else begin
                        state_r       <= ST_RUN;
                        redirect_r    <= 1'b0;
                        redirect_pc_r <= 32'h0000_0000;
                    end
                end
                ST_ENTRY, ST_RETURN: begin
                    state_r       <= ST_RUN;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= 32'h0000_0000;
                end
                default: begin
                    state_r       <= ST_RUN;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    // SR update. Trap entry sets EXL, and ERET clears it after any same-cycle MTC0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_im_r  <= 6'b000000;
            sr_exl_r <= 1'b0;
            sr_ie_r  <= 1'b0;
        end else begin
            if (mtc0_go_s && (cp0_addr == ADDR_SR)) begin
                sr_im_r <= cp0_wdata[15:10];
                sr_ie_r <= cp0_wdata[0];
            end else begin
                sr_im_r <= sr_im_r;
                sr_ie_r <= sr_ie_r;
            end
            if (take_s) begin
                sr_exl_r <= 1'b1;
            end else if (eret_go_s) begin
                sr_exl_r <= 1'b0;
            end else if (mtc0_go_s && (cp0_addr == ADDR_SR)) begin
                sr_exl_r <= cp0_wdata[1];
            end else begin
                sr_exl_r <= sr_exl_r;
            end
        end
    end

    // Cause update. IP tracks the interrupt lines every cycle. An interrupt reports ExcCode 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_bd_r   <= 1'b0;
            cause_code_r <= 5'd0;
            cause_ip_r   <= 6'b000000;
        end else begin
            cause_ip_r <= hwint;
            if (take_s) begin
                cause_bd_r   <= bd_m;
                cause_code_r <= int_p_s ? 5'd0 : exccode_m;
            end else begin
                cause_bd_r   <= cause_bd_r;
                cause_code_r <= cause_code_r;
            end
        end
    end

    // EPC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_r <= 32'h0000_0000;
        end else begin
            epc_r <= epc_next_s;
        end
    end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Self-checking bench for cp0_exc_seq: directed scenarios followed by
// randomized traffic, all compared against a behavioural CP0 model.
module tb_cp0_exc_seq;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam logic [31:0] PRID    = 32'h2017_1226;

    logic        clk;
    logic        rst_n;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode_m;
    logic [5:0]  hwint;
    logic        eret_m;
    logic        mtc0_m;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exl;

    cp0_exc_seq dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
        .exccode_m(exccode_m), .hwint(hwint), .eret_m(eret_m), .mtc0_m(mtc0_m),
        .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .exl(exl)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (architectural view).
    logic [5:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic        m_bd;
    logic [4:0]  m_code;
    logic [5:0]  m_ip;
    logic [31:0] m_epc;
    bit          m_pending;   // a redirect is owed in the current cycle
    logic [31:0] m_target;
    logic        last_flush;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_im = 6'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_code = 5'd0;
        m_ip = 6'd0; m_epc = 32'd0; m_pending = 1'b0; m_target = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        logic [31:0] v;
        v = 32'd0;
        if (addr == 5'd12)
            v = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
        else if (addr == 5'd13)
            v = (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
        else if (addr == 5'd14)
            v = m_epc;
        else if (addr == 5'd15)
            v = PRID;
        return v;
    endfunction

    // One clock cycle: drive in the low phase, check, update the model, return just after the edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic bd,
                         input logic [4:0] code, input logic [5:0] hw, input logic er,
                         input logic mt, input logic [4:0] addr, input logic [31:0] wd);
        bit intr, take, eret_go, mt_go;
        logic e_flush, e_redir;
        logic [31:0] e_pc;
        @(negedge clk);
        valid_m = v; pc_m = pc; bd_m = bd; exccode_m = code; hwint = hw;
        eret_m = er; mtc0_m = mt; cp0_addr = addr; cp0_wdata = wd;
        #1;
        intr = ((hw & m_im) != 6'd0) && m_ie && !m_exl;
        if (m_pending) begin
            take = 1'b0; eret_go = 1'b0; mt_go = 1'b0;
            e_flush = 1'b1; e_redir = 1'b1; e_pc = m_target;
        end else begin
            take    = v && (intr || (code != 5'd0));
            eret_go = v && er && !take;
            mt_go   = v && mt && !take;
            e_flush = take || eret_go;
            e_redir = 1'b0; e_pc = 32'd0;
        end
        check_val("flush", 32'(flush), 32'(e_flush));
        check_val("redirect", 32'(redirect), 32'(e_redir));
        check_val("redirect_pc", redirect_pc, e_pc);
        check_val("rdata", cp0_rdata, model_read(addr));
        check_val("exl", 32'(exl), 32'(m_exl));
        last_flush = flush;
        if (m_pending) begin
            m_pending = 1'b0;
        end else if (take) begin
            m_epc = bd ? pc - 32'd4 : pc;
            m_bd = bd;
            m_code = intr ? 5'd0 : code;
            m_exl = 1'b1;
            m_pending = 1'b1;
            m_target = HANDLER;
        end else begin
            if (mt_go && addr == 5'd12) begin
                m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
            end
            if (mt_go && addr == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
            if (eret_go) begin
                m_exl = 1'b0; m_pending = 1'b1; m_target = m_epc;
            end
        end
        m_ip = hw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] hw);
        cycle(1'b0, 32'd0, 1'b0, 5'd0, hw, 1'b0, 1'b0, 5'd12, 32'd0);
    endtask

    // Read a CP0 register in the high phase without disturbing the model.
    task automatic peek(input logic [4:0] addr, output logic [31:0] val);
        valid_m = 1'b0; eret_m = 1'b0; mtc0_m = 1'b0; exccode_m = 5'd0;
        cp0_addr = addr;
        #1;
        val = cp0_rdata;
    endtask

    // Pulse reset while a redirect is pending and confirm everything clears.
    task automatic reset_mid(input string tag);
        logic [31:0] r;
        valid_m = 1'b0; eret_m = 1'b0; mtc0_m = 1'b0; exccode_m = 5'd0; hwint = 6'd0;
        rst_n = 1'b0;
        #1;
        check_val({tag, "_redirect"}, 32'(redirect), 32'd0);
        check_val({tag, "_flush"}, 32'(flush), 32'd0);
        check_val({tag, "_rpc"}, redirect_pc, 32'd0);
        peek(5'd12, r); check_val({tag, "_sr"}, r, 32'd0);
        peek(5'd14, r); check_val({tag, "_epc"}, r, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        valid_m = 1'b0; pc_m = 32'd0; bd_m = 1'b0; exccode_m = 5'd0; hwint = 6'd0;
        eret_m = 1'b0; mtc0_m = 1'b0; cp0_addr = 5'd12; cp0_wdata = 32'd0;
        last_flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        peek(5'd12, r); check_val("rst_sr", r, 32'd0);
        peek(5'd14, r); check_val("rst_epc", r, 32'd0);
        check_val("rst_flush", 32'(flush), 32'd0);
        check_val("rst_redirect", 32'(redirect), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6'd0);

        // AdES without delay slot.
        cycle(1'b1, 32'h3010, 1'b0, 5'd5, 6'd0, 1'b0, 1'b0, 5'd14, 32'd0);
        check_val("ades_flush", 32'(last_flush), 32'd1);
        check_val("ades_redirect", 32'(redirect), 32'd1);
        check_val("ades_vector", redirect_pc, HANDLER);
        peek(5'd14, r); check_val("ades_epc", r, 32'h3010);
        peek(5'd13, r); check_val("ades_code", 32'(r[6:2]), 32'd5);
        peek(5'd12, r); check_val("ades_exl", 32'(r[1]), 32'd1);
        idle(6'd0);

        // AdEL in a delay slot.
        cycle(1'b1, 32'h3020, 1'b1, 5'd4, 6'd0, 1'b0, 1'b0, 5'd13, 32'd0);
        peek(5'd14, r); check_val("bd_epc", r, 32'h301C);
        peek(5'd13, r); check_val("bd_cause31", 32'(r[31]), 32'd1);
        idle(6'd0);

        // Interrupt wins over a simultaneous AdES.
        cycle(1'b1, 32'h3028, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 5'd12, 32'h0000_0401);
        cycle(1'b1, 32'h3030, 1'b0, 5'd5, 6'b000001, 1'b0, 1'b0, 5'd12, 32'd0);
        peek(5'd13, r);
        check_val("int_code", 32'(r[6:2]), 32'd0);
        check_val("int_ip10", 32'(r[10]), 32'd1);
        peek(5'd14, r); check_val("int_epc", r, 32'h3030);
        check_val("int_vector", redirect_pc, HANDLER);
        idle(6'd0);

        // ERET to 0x3040, then a held interrupt is taken once EXL clears.
        cycle(1'b1, 32'h3038, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 5'd14, 32'h3040);
        cycle(1'b1, 32'h303C, 1'b0, 5'd0, 6'b000001, 1'b1, 1'b0, 5'd14, 32'd0);
        check_val("eret_flush", 32'(last_flush), 32'd1);
        check_val("eret_target", redirect_pc, 32'h3040);
        peek(5'd12, r); check_val("eret_exl", 32'(r[1]), 32'd0);
        idle(6'b000001);
        cycle(1'b1, 32'h3050, 1'b0, 5'd0, 6'b000001, 1'b0, 1'b0, 5'd12, 32'd0);
        check_val("late_int_flush", 32'(last_flush), 32'd1);
        check_val("late_int_vector", redirect_pc, HANDLER);
        peek(5'd14, r); check_val("late_int_epc", r, 32'h3050);
        idle(6'd0);

        // MTC0 EPC aligns the value. A trapping MTC0 does not write.
        cycle(1'b1, 32'h3058, 1'b0, 5'd0, 6'd0, 1'b0, 1'b1, 5'd14, 32'h3047);
        peek(5'd14, r); check_val("mtc0_epc", r, 32'h3044);
        cycle(1'b1, 32'h3060, 1'b0, 5'd5, 6'd0, 1'b0, 1'b1, 5'd14, 32'hDEAD_0000);
        peek(5'd14, r); check_val("trap_mtc0_epc", r, 32'h3060);
        idle(6'd0);

        // Delay-slot trap at PC 0 wraps.
        cycle(1'b1, 32'd0, 1'b1, 5'd4, 6'd0, 1'b0, 1'b0, 5'd14, 32'd0);
        peek(5'd14, r); check_val("wrap_epc", r, 32'hFFFF_FFFC);
        idle(6'd0);

        // PRId and unmapped reads.
        cycle(1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 5'd15, 32'd0);
        peek(5'd15, r); check_val("prid", r, PRID);
        peek(5'd3, r);  check_val("unmapped", r, 32'd0);

        // Reset in the middle of ENTRY and of RETURN.
        cycle(1'b1, 32'h3070, 1'b0, 5'd5, 6'd0, 1'b0, 1'b0, 5'd12, 32'd0);
        reset_mid("rst_entry");
        cycle(1'b1, 32'h3074, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 5'd12, 32'd0);
        reset_mid("rst_return");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        v, bd, er, mt;
            logic [4:0]  code, addr;
            logic [5:0]  hw;
            logic [31:0] pc, wd;
            v    = ($urandom_range(0, 9) < 8);
            bd   = 1'($urandom_range(0, 1));
            code = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'd0;
            hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            er   = ($urandom_range(0, 7) == 0);
            mt   = ($urandom_range(0, 4) == 0);
            addr = 5'($urandom_range(10, 16));
            pc   = $urandom;
            wd   = $urandom;
            cycle(v, pc, bd, code, hw, er, mt, addr, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
